// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame-aware UART receive sequencer.
//
// Detects a start bit on the synchronized serial line. It times mid-bit
// sampling from the oversampled BaudTick and shifts DATA_WIDTH data bits in
// LSB-first. It then checks the optional parity bit and the stop bit, and
// hands a parallel word to the host over a valid/ack handshake.
//
// Ports
//   Clock        system clock
//   Reset        asynchronous, active-high reset
//   BaudTick     one-Clock enable, OVERSAMPLE pulses per bit period
//   DataTx       serial line (idle high, asynchronous to Clock)
//   ParityType   00 none, 01 odd, 10 even, 11 none (latched per frame)
//   DataAck      host has consumed DataOut
//   DataOut      received word, bit 0 = first data bit on the line
//   DataValid    DataOut holds an unconsumed word
//   ParityError  parity mismatch on the word in DataOut
//   FrameError   stop bit sampled low on the word in DataOut
//   Overrun      a word was overwritten before DataAck (sticky until ack)
//   Busy         sequencer not idle
//
// Build option
//   MAJORITY_VOTE_EN  when defined, every bit decision is the 2-of-3 majority
//                     of samples at ticks mid-1, mid and mid+1, taken on mid+1.
//
// state  | meaning
// IDLE   | waiting for a low line on a BaudTick
// START  | timing to the start-bit centre, rejecting glitches
// DATA   | sampling DATA_WIDTH data bits, LSB first
// PARITY | sampling the parity bit (odd/even frames only)
// STOP   | sampling the stop bit
// DONE   | one Clock: publish word, flags and overrun
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  BaudTick,
    input  logic                  DataTx,
    input  logic [1:0]            ParityType,
    input  logic                  DataAck,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  DataValid,
    output logic                  ParityError,
    output logic                  FrameError,
    output logic                  Overrun,
    output logic                  Busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] MID_START = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] MID_BIT   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            sync_q, sync_d;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_odd_q, par_odd_d;
    logic                  par_err_q, par_err_d;
    logic                  frm_err_q, frm_err_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;

    logic          rx_s;
    logic          start_ev, start_val, bit_ev, bit_val;
    logic [TW-1:0] bit_tick_nxt;

    assign sync_d = {sync_q[0], DataTx};
    assign rx_s   = sync_q[1];

`ifdef MAJORITY_VOTE_EN
    localparam logic [TW-1:0] START_M1 = TW'(OVERSAMPLE / 2 - 2);
    localparam logic [TW-1:0] START_P1 = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] BIT_M1   = TW'(OVERSAMPLE - 2);

    logic s1_q, s1_d, s2_q, s2_d, pend_q, pend_d;
    logic vote;

    assign vote      = (s1_q & s2_q) | (s1_q & rx_s) | (s2_q & rx_s);
    assign start_ev  = BaudTick && (tick_cnt_q == START_P1);
    assign start_val = vote;
    // Bit periods after START free-run modulo OVERSAMPLE; the mid+1 sample is
    // the first tick of the following period, so the decision is deferred by
    // one tick via pend_q without shifting the bit grid.
    assign bit_ev    = BaudTick && pend_q;
    assign bit_val   = vote;
    assign bit_tick_nxt = !BaudTick ? tick_cnt_q :
                          (tick_cnt_q == MID_BIT) ? '0 : tick_cnt_q + TW'(1);

    always_comb begin
        s1_d   = s1_q;
        s2_d   = s2_q;
        pend_d = pend_q;
        if (BaudTick) begin
            if (state_q == S_START) begin
                if (tick_cnt_q == START_M1) s1_d = rx_s;
                if (tick_cnt_q == MID_START) s2_d = rx_s;
            end else if (state_q inside {S_DATA, S_PARITY, S_STOP}) begin
                if (tick_cnt_q == BIT_M1) s1_d = rx_s;
                if (tick_cnt_q == MID_BIT) begin
                    s2_d   = rx_s;
                    pend_d = 1'b1;
                end
            end
        end
        if (bit_ev || state_q == S_IDLE) pend_d = 1'b0;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            pend_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            pend_q <= pend_d;
        end
    end
`else
    assign start_ev     = BaudTick && (tick_cnt_q == MID_START);
    assign start_val    = rx_s;
    assign bit_ev       = BaudTick && (tick_cnt_q == MID_BIT);
    assign bit_val      = rx_s;
    assign bit_tick_nxt = bit_ev ? '0 : BaudTick ? tick_cnt_q + TW'(1) : tick_cnt_q;
`endif

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            sync_q     <= 2'b11;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    // Next state and frame datapath
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        case (state_q)
            S_IDLE: begin
                if (BaudTick && !rx_s) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    par_en_d   = (ParityType == 2'b01) || (ParityType == 2'b10);
                    par_odd_d  = (ParityType == 2'b01);
                    par_err_d  = 1'b0;
                end
            end
            S_START: begin
                if (start_ev) begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = start_val ? S_IDLE : S_DATA;
                end else if (BaudTick) begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
            S_DATA: begin
                tick_cnt_d = bit_tick_nxt;
                if (bit_ev) begin
                    // Shifting in from the top leaves the first bit at [0].
                    shift_d   = {bit_val, shift_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == LAST_BIT) state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                tick_cnt_d = bit_tick_nxt;
                if (bit_ev) begin
                    par_err_d = ((^shift_q) ^ bit_val) != par_odd_q;
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                tick_cnt_d = bit_tick_nxt;
                if (bit_ev) begin
                    frm_err_d = !bit_val;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Host-facing outputs and handshake
    always_comb begin
        data_out_d = data_out_q;
        valid_d    = valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;
        if (DataAck && valid_q) begin
            valid_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end
        // A word completing in the ack cycle replaces the consumed one.
        if (state_q == S_DONE) begin
            data_out_d = shift_q;
            valid_d    = 1'b1;
            perr_d     = par_err_q;
            ferr_d     = frm_err_q;
            if (valid_q && !DataAck) ovr_d = 1'b1;
        end
        DataOut     = data_out_q;
        DataValid   = valid_q;
        ParityError = perr_q;
        FrameError  = ferr_q;
        Overrun     = ovr_q;
        Busy        = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
    localparam int DW = 8;
    localparam int OS = 16;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          BaudTick;
    logic          DataTx;
    logic [1:0]    ParityType;
    logic          DataAck;
    logic [DW-1:0] DataOut;
    logic          DataValid;
    logic          ParityError;
    logic          FrameError;
    logic          Overrun;
    logic          Busy;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .Clock(Clock), .Reset(Reset), .BaudTick(BaudTick), .DataTx(DataTx),
        .ParityType(ParityType), .DataAck(DataAck), .DataOut(DataOut),
        .DataValid(DataValid), .ParityError(ParityError), .FrameError(FrameError),
        .Overrun(Overrun), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    // BaudTick: one Clock in every three, changed on the falling edge.
    int tick_div = 0;
    initial begin
        BaudTick = 1'b0;
        forever begin
            @(negedge Clock);
            tick_div = (tick_div == 2) ? 0 : tick_div + 1;
            BaudTick = (tick_div == 0);
        end
    end

    typedef struct packed {
        logic [DW-1:0] d;
        logic          pe;
        logic          fe;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    bit   auto_ack   = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Reference: parity error from the count of ones on the line.
    function automatic logic model_pe(input logic [DW-1:0] d, input logic [1:0] pt, input logic pbit);
        int ones;
        ones = $countones(d) + int'(pbit);
        if (pt == 2'b01) return (ones % 2) != 1;
        if (pt == 2'b10) return (ones % 2) != 0;
        return 1'b0;
    endfunction

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge Clock);
            if (BaudTick) c++;
        end
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic [1:0] pt, input logic pbit,
                              input logic stop, input logic push, input logic [1:0] pt_mid);
        exp_t e;
        ParityType = pt;
        if (push) begin
            e.d  = d;
            e.pe = model_pe(d, pt, pbit);
            e.fe = !stop;
            exp_q.push_back(e);
        end
        DataTx = 1'b0;
        wait_ticks(4);
        ParityType = pt_mid;
        wait_ticks(OS - 4);
        for (int i = 0; i < DW; i++) begin
            DataTx = d[i];
            wait_ticks(OS);
        end
        if (pt == 2'b01 || pt == 2'b10) begin
            DataTx = pbit;
            wait_ticks(OS);
        end
        DataTx = stop;
        wait_ticks(OS);
        DataTx = 1'b1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || DataValid) && n < 4000) begin
            @(posedge Clock);
            n++;
        end
        #1;
        compared++;
        if (exp_q.size() != 0 || DataValid) begin
            mismatched++;
            $display("FAIL drain: actual %0d words outstanding, required 0", exp_q.size());
        end
        @(posedge Clock);
        #1;
    endtask

    // Monitor: pops the expected word whenever the DUT presents one, then acks.
    initial begin
        exp_t e;
        DataAck = 1'b0;
        forever begin
            @(negedge Clock);
            if (auto_ack && DataValid && !Reset) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_word: actual %0h with nothing outstanding, required none", DataOut);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", DataOut, e.d);
                    check("word_parity_err", ParityError, e.pe);
                    check("word_frame_err", FrameError, e.fe);
                    check("word_overrun", Overrun, 0);
                    check("word_busy", Busy, 0);
                end
                DataAck = 1'b1;
                @(posedge Clock);
                #1 DataAck = 1'b0;
                @(negedge Clock);
                check("ack_clears_valid", DataValid, 0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [1:0]    pt, ptm;
        logic          pbit, stop;

        Reset      = 1'b1;
        DataTx     = 1'b1;
        ParityType = 2'b00;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_dataout", DataOut, 0);
        check("rst_valid", DataValid, 0);
        check("rst_perr", ParityError, 0);
        check("rst_ferr", FrameError, 0);
        check("rst_overrun", Overrun, 0);
        check("rst_busy", Busy, 0);
        @(posedge Clock);
        #1 Reset = 1'b0;
        wait_ticks(4);

        // Basic frame
        send_frame(8'h5A, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00);
        wait_drain();
        check("basic_busy_idle", Busy, 0);

        // Glitch shorter than half a bit
        DataTx = 1'b0;
        wait_ticks(4);
        DataTx = 1'b1;
        wait_ticks(30);
        check("glitch_busy", Busy, 0);
        check("glitch_valid", DataValid, 0);
        check("glitch_ferr", FrameError, 0);
        check("glitch_overrun", Overrun, 0);

        // Even parity, bad then good parity bit
        send_frame(8'h07, 2'b10, 1'b0, 1'b1, 1'b1, 2'b10);
        wait_ticks(2);
        send_frame(8'h07, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10);
        wait_drain();

        // Stop bit low, then a good frame once the line is back high
        send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
        wait_ticks(20);
        send_frame(8'hC3, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00);
        wait_drain();
        wait_ticks(2);

        // Overrun: two words without ack
        auto_ack = 1'b0;
        send_frame(8'h11, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00);
        wait_ticks(2);
        send_frame(8'h22, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00);
        wait_ticks(2);
        check("ovr_data", DataOut, 8'h22);
        check("ovr_valid", DataValid, 1);
        check("ovr_flag", Overrun, 1);
        @(negedge Clock);
        DataAck = 1'b1;
        @(posedge Clock);
        #1 DataAck = 1'b0;
        check("ovr_ack_valid", DataValid, 0);
        check("ovr_ack_flag", Overrun, 0);

        // Leave a flagged word pending, then reset in the middle of data bit 3
        send_frame(8'h33, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01);
        wait_ticks(2);
        check("pend_valid", DataValid, 1);
        check("pend_perr", ParityError, model_pe(8'h33, 2'b01, 1'b0));
        check("pend_ferr", FrameError, 1);
        d = 8'hF6;
        ParityType = 2'b00;
        DataTx = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 3; i++) begin
            DataTx = d[i];
            wait_ticks(OS);
        end
        DataTx = d[3];
        wait_ticks(OS / 2);
        check("midframe_busy", Busy, 1);
        Reset  = 1'b1;
        DataTx = 1'b1;
        #1;
        check("midrst_dataout", DataOut, 0);
        check("midrst_valid", DataValid, 0);
        check("midrst_perr", ParityError, 0);
        check("midrst_ferr", FrameError, 0);
        check("midrst_busy", Busy, 0);
        @(posedge Clock);
        @(posedge Clock);
        #1 Reset = 1'b0;
        auto_ack = 1'b1;
        wait_ticks(4);
        send_frame(8'hA5, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00);
        wait_drain();

        // Randomized frames against the reference model
        for (int n = 0; n < 30; n++) begin
            d    = DW'($urandom_range(0, 255));
            pt   = 2'($urandom_range(0, 3));
            ptm  = 2'($urandom_range(0, 3));
            pbit = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 5) != 0);
            send_frame(d, pt, pbit, stop, 1'b1, ptm);
            if (stop) wait_ticks(int'($urandom_range(0, 12)));
            else      wait_ticks(20 + int'($urandom_range(0, 8)));
        end
        wait_drain();
        check("final_busy", Busy, 0);
        check("final_overrun", Overrun, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART Rx path. Detects the start bit on the serial line, times mid-bit sampling from an oversampled baud tick and shifts data bits in LSB-first. It then checks parity and stop bit and presents a parallel word to the host with a valid/ack handshake. It sits between the baud generator and the Rx register/host interface, and replaces free-running shifting with frame-aware sequencing.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9)
OVERSAMPLE, 16, BaudTick pulses per bit period (even, >=4)

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
BaudTick  in  1  one-Clock enable pulse, OVERSAMPLE per bit
DataTx  in  1  serial line, idle high, asynchronous to Clock
ParityType  in  2  00 none, 01 odd, 10 even, 11 treated as none
DataAck  in  1  host consumed DataOut
DataOut  out  DATA_WIDTH  received word, LSB = first data bit
DataValid  out  1  DataOut holds an unconsumed word
ParityError  out  1  parity mismatch on the word in DataOut
FrameError  out  1  stop bit sampled low on the word in DataOut
Overrun  out  1  a word was overwritten before DataAck (sticky)
Busy  out  1  FSM not in IDLE

Behaviour:
- Reset is asynchronous and active-high. One clock domain, Clock.
- DataTx passes through a 2-flop synchronizer, reset value 1. All FSM decisions use the synchronized bit RxS.
- Reset values:
  - DataOut = 0.
  - DataValid, ParityError, FrameError, Overrun, Busy = 0.
  - FSM = IDLE, tick counter = 0, bit counter = 0.
- FSM states, advancing only on Clock cycles with BaudTick=1:
  - IDLE: on BaudTick with RxS=0, go to START and set tick count = 0.
  - START: count ticks. At count OVERSAMPLE/2-1 (mid-bit):
    - RxS=0: go to DATA, tick count = 0, bit index = 0.
    - RxS=1: false start, return to IDLE with no flags changed.
  - DATA: sample RxS into shift register bit [index] when tick count = OVERSAMPLE-1, then clear tick count.
    - After DATA_WIDTH samples: go to PARITY if ParityType is 01/10, else STOP.
  - PARITY: sample at tick count OVERSAMPLE-1.
    - Error = (XOR of data ^ parity bit) != (ParityType==01).
  - STOP: sample at tick count OVERSAMPLE-1, then go to DONE.
  - DONE (one Clock, independent of BaudTick):
    - DataOut <= shift register; DataValid <= 1.
    - ParityError and FrameError <= this frame's results.
    - If DataValid was already 1 and no DataAck this cycle, Overrun <= 1.
    - Next state IDLE.
- ParityType is sampled on entry to START and held for the frame. Changes mid-frame have no effect until the next frame.
- Handshake:
  - DataValid stays high until a Clock with DataAck=1, then 0 on the next cycle.
  - DataAck while DataValid=0 is ignored.
  - DataAck in the same cycle as DONE: the new word wins, DataValid stays 1, Overrun is not set.
  - Overrun clears on DataAck.
  - ParityError and FrameError are valid only while DataValid=1.
- Data timing: a new word appears 1 Clock after the STOP mid-bit tick. Busy falls in the same cycle DataValid rises.
- A stop bit sampled low still delivers the word, with FrameError=1. The FSM returns to IDLE and re-arms for a start bit; a held-low line re-enters START on the next tick.
- Counters: tick counter is $clog2(OVERSAMPLE) bits. Bit counter is $clog2(DATA_WIDTH+1) bits. Neither wraps inside a state.

Optional Feature:
MAJORITY_VOTE_EN
- Defined: each bit sample (start check, data, parity, stop) is the 2-of-3 majority of RxS at ticks mid-1, mid and mid+1. Mid is OVERSAMPLE/2-1 for START and OVERSAMPLE-1 for later states. The decision is taken on the mid+1 tick, so the word appears 2 BaudTicks later than single-sample mode.
- Undefined: single sample at mid tick as described above.

Test Plan:
- Settings: OVERSAMPLE=16, ParityType=00. Frame 0x5A with stop=1 -> DataOut=0x5A, DataValid=1, ParityError=0, FrameError=0, Busy=0 after DONE.
- Glitch: DataTx low for 4 BaudTicks then high -> FSM back in IDLE, DataValid stays 0, no flags.
- Parity: ParityType=10 (even), send 0x07 with parity bit 0 -> ParityError=1. Repeat with parity bit 1 -> ParityError=0.
- Framing: stop bit held low -> DataValid=1 with FrameError=1. The next good frame is received correctly after the line returns high.
- Overrun: two frames 0x11 then 0x22 with no DataAck -> DataOut=0x22, Overrun=1. DataAck -> DataValid=0 and Overrun=0 on the next Clock.
- Reset mid-frame: assert Reset during DATA bit 3 -> all outputs 0 immediately, FSM in IDLE. The following full frame 0xA5 is received correctly.
